// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and helpers for the seq_detect_moore detector.
//   DEF_PAT_W / DEF_RST_PAT / DEF_CNT_W : default parameter values
//   clog2()                             : ceiling log2, used to size the fill count
//   fill_t                              : fill count type for the default pattern width
package seq_det_pkg;

   localparam int          DEF_PAT_W   = 4;
   localparam logic [31:0] DEF_RST_PAT = 32'h0000_000B;  // 4'b1011
   localparam int          DEF_CNT_W   = 8;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

   typedef logic [clog2(DEF_PAT_W + 1) - 1:0] fill_t;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: generic saturating up-counter.
//   clk, rst : clock, synchronous active-high reset
//   inc      : add one this edge (held once all-ones)
//   clr      : clear this edge; clr together with inc loads 1
//   cnt      : current count
//   sat      : high while cnt is all-ones
module seq_det_sat_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   assign sat = &cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= inc ? CNT_W'(1) : '0;
      end else if (inc && !sat) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_detect_moore.sv
// seq_detect_moore: Moore serial sequence detector with a runtime-loadable pattern.
//   clk, rst   : clock, synchronous active-high reset
//   x, x_valid : serial bit and its qualifier
//   ovl        : 1 = overlapping detection, 0 = non-overlapping
//   pat_load   : load pat_in (MSB is the first bit received) and discard history
//   cnt_clr    : clear the match counter
//   y          : registered match output
//   match_cnt  : saturating match count, cnt_sat high while it is all-ones
// Build option: SEQ_DET_CNT_EN enables the match counter; without it match_cnt
// and cnt_sat are tied to 0 and cnt_clr is ignored.
module seq_detect_moore
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
   parameter int               CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x,
   input  logic             x_valid,
   input  logic             ovl,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             y,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int FILL_W = clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  pat_q;
   logic [PAT_W-1:0]  hist;
   logic [PAT_W-1:0]  hist_n;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_inc;
   logic              y_q;
   logic              y_n;
   logic              hit;

   always_comb begin
      hist_n   = {hist[PAT_W-2:0], x};
      fill_inc = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
      y_n      = (fill_inc == FILL_FULL) && (hist_n == pat_q);
   end

   // A match is only registered on an accepted bit that is not overridden.
   assign hit = !rst && !pat_load && x_valid && y_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q <= RST_PAT;
         hist  <= '0;
         fill  <= '0;
         y_q   <= 1'b0;
      end else if (pat_load) begin
         pat_q <= pat_in;
         hist  <= '0;
         fill  <= '0;
         y_q   <= 1'b0;
      end else if (x_valid) begin
         hist <= hist_n;
         // Non-overlapping mode restarts the fill so the next match needs fresh bits.
         fill <= (y_n && !ovl) ? '0 : fill_inc;
         y_q  <= y_n;
      end
   end

   assign y = y_q;

`ifdef SEQ_DET_CNT_EN
   seq_det_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_sat_cnt (
      .clk (clk),
      .rst (rst),
      .inc (hit),
      .clr (cnt_clr),
      .cnt (match_cnt),
      .sat (cnt_sat)
   );
`else
   logic unused_cnt;
   assign unused_cnt = hit ^ cnt_clr;
   assign match_cnt  = '0;
   assign cnt_sat    = 1'b0;
`endif

endmodule

// File: doc/seq_detect_moore.md
# seq_detect_moore

Parametrised Moore-type serial sequence detector. It samples a 1-bit serial input and asserts a registered output when the last PAT_W accepted bits equal a runtime-loadable pattern. It supports overlapping and non-overlapping detection and an optional saturating match counter. It is the generalised successor to the team's fixed 3-flop hard-coded detectors and sits directly on serial control or data lines.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..32.
- RST_PAT, 4'b1011, pattern value loaded at reset; PAT_W bits wide.
- CNT_W, 8, match counter width; legal range 1..32.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- x  input  1  serial data bit.
- x_valid  input  1  x is accepted on a clk edge only when this is high.
- ovl  input  1  1 = overlapping detection, 0 = non-overlapping; sampled on every accepted bit.
- pat_load  input  1  loads pat_in on this edge.
- pat_in  input  PAT_W  new pattern; the MSB is the first bit received.
- cnt_clr  input  1  clears the match counter.
- y  output  1  Moore match output, driven from a state register only.
- match_cnt  output  CNT_W  number of matches since reset or clear.
- cnt_sat  output  1  high while match_cnt is all-ones.

## Operation
- State registers:
  - pat_q (PAT_W): the active pattern.
  - hist (PAT_W): the last accepted bits; shifts left, with x entering at the LSB.
  - fill (clog2(PAT_W+1) bits): number of valid bits in hist; saturates at PAT_W.
  - y_q: the match state.
- Priority on each edge is rst > pat_load > x_valid > idle.
- rst:
  - pat_q=RST_PAT, hist=0, fill=0.
  - y=0, match_cnt=0, cnt_sat=0.
- pat_load:
  - pat_q=pat_in, hist=0, fill=0, y=0.
  - x is ignored that cycle.
  - match_cnt is unchanged; cnt_clr is still honoured.
- Accepted bit (x_valid=1, no load):
  - hist_n={hist[PAT_W-2:0],x}.
  - fill_n=min(fill+1,PAT_W).
  - y_n=(fill_n==PAT_W)&&(hist_n==pat_q).
  - If y_n and ovl=0, fill is forced to 0, so the next match needs PAT_W fresh bits.
  - If y_n and ovl=1, fill stays at PAT_W.
- Idle (x_valid=0): all state holds, so y holds its value across gaps.
- Counter:
  - Increments by 1 on each edge where y_n=1 is registered.
  - Repeated consecutive matches (for example an all-ones pattern with ovl=1) count once per accepted bit.
  - Saturates at 2^CNT_W-1.
  - cnt_clr together with a match gives 1; cnt_clr alone gives 0.
  - cnt_sat = &match_cnt.

## Timing
- Latency: y rises in the cycle following the edge that accepts the final pattern bit. There is no combinational path from x to y.
- y stays high until the next accepted bit, pat_load or rst.
- match_cnt updates on the same edge as y.
- Reset mid-stream discards partial history; the first match after reset needs PAT_W accepted bits.
- pat_load mid-stream behaves the same way: partial history is discarded.
- pat_load during a y=1 cycle drops y on the next cycle.

## Configuration
- SEQ_DET_CNT_EN defined: the match counter, cnt_clr and cnt_sat logic are present.
- Not defined:
  - match_cnt is tied to 0 and cnt_sat is tied to 0.
  - cnt_clr is ignored.
  - The port list is unchanged.
  - Detection behaviour is identical in both builds.

## Structure
- Package seq_det_pkg holds:
  - default PAT_W, RST_PAT and CNT_W constants;
  - a clog2 function for sizing fill;
  - a typedef for the fill count.
- One sub-module: seq_det_sat_cnt, a generic CNT_W saturating counter with inc, clr and sat. It is instantiated only under SEQ_DET_CNT_EN.
- The detector core (hist, fill, pat_q, y) stays in the top module.

## Test plan
All scenarios use PAT_W=4 and pattern 1011.
- Match after reset: reset, then accept 1,0,1,1 -> y=1 exactly one cycle after the 4th accept edge; match_cnt=1; y was 0 on all earlier cycles.
- Overlap vs non-overlap: accept 1,0,1,1,0,1,1.
  - With ovl=1 -> y pulses after the 4th and 7th bits; match_cnt=2.
  - With ovl=0 -> one match only; match_cnt=1.
- Gaps: accept 1,0,1,1, then hold x_valid=0 for 5 cycles -> y stays 1 for all 5 cycles; the next accepted 0 drops y; match_cnt stays 1.
- Load mid-stream: accept 1,0,1, then pat_load with pat_in=0110, then accept 1 -> no match. Continue with 0,1,1,0 -> y=1 after the final 0.
- Counter saturation: CNT_W=2, produce 5 matches -> match_cnt=3 and cnt_sat=1. Then cnt_clr together with a match -> match_cnt=1.
- Reset mid-operation: accept 1,0,1, assert rst for 1 cycle, accept 1 -> y=0 and match_cnt=0. Then 0,1,1 -> y=1 only after a further full 1,0,1,1.
- Build without SEQ_DET_CNT_EN -> match_cnt and cnt_sat stay 0 throughout every scenario above.
